// File: rtl/exec_muldiv_stg.sv
// rtl/exec_muldiv_stg.sv - execute-stage HI/LO registers with iterative multiply/divide engine
module exec_muldiv_stg #(
    parameter int XLEN  = 32,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_s0,
    input  logic [XLEN-1:0]  in_s1,
    input  logic             in_dst_vld,
    input  logic [REG_W-1:0] in_dst_reg,
    input  logic             bubble,
    input  logic             flush,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic             out_dst_vld,
    output logic [REG_W-1:0] out_dst_reg,
    output logic [XLEN-1:0]  out_data,
    output logic             busy,
    output logic [XLEN-1:0]  hi,
    output logic [XLEN-1:0]  lo
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {
        E_IDLE,
        E_RUN,
        E_FIX
    } eng_t;

    eng_t state, state_nxt;

    // Holding register (one packet)
    logic             held;
    logic [3:0]       h_op;
    logic [XLEN-1:0]  h_s0;
    logic [XLEN-1:0]  h_s1;
    logic             h_dst_vld;
    logic [REG_W-1:0] h_dst_reg;

    // Engine working state: acc_hi/acc_lo is the product, or remainder/quotient
    logic [CW-1:0]    count;
    logic             e_div;
    logic             e_div0;
    logic             e_neg_res;
    logic             e_neg_rem;
    logic [XLEN-1:0]  e_a;
    logic [XLEN-1:0]  e_b;
    logic [XLEN-1:0]  acc_hi;
    logic [XLEN-1:0]  acc_lo;

    logic h_is_md, h_is_mf, h_is_mt, h_signed;
    logic interlock, fire, accept, start;
    logic a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] prod_neg;
    logic [XLEN-1:0]   fix_hi, fix_lo;

    // Handshake, decode and output steering
    always_comb begin
        h_is_md   = (h_op == OP_MULT) || (h_op == OP_MULTU) || (h_op == OP_DIV) || (h_op == OP_DIVU);
        h_is_mf   = (h_op == OP_MFHI) || (h_op == OP_MFLO);
        h_is_mt   = (h_op == OP_MTHI) || (h_op == OP_MTLO);
        h_signed  = (h_op == OP_MULT) || (h_op == OP_DIV);
        interlock = busy && (h_is_md || h_is_mf || h_is_mt);
        out_vld   = held && !bubble && !interlock;
        fire      = out_vld && out_rdy;
        in_rdy    = !held || fire || bubble;
        accept    = in_vld && in_rdy && !flush;
        start     = fire && h_is_md && !flush;

        out_dst_vld = held && h_dst_vld && !h_is_md && !h_is_mt;
        out_dst_reg = h_dst_reg;
        out_data    = '0;
        if (h_op == OP_MFHI)
            out_data = hi;
        else if (h_op == OP_MFLO)
            out_data = lo;
        else if (!h_is_md && !h_is_mt)
            out_data = h_s0;

        a_neg = h_signed && h_s0[XLEN-1];
        b_neg = h_signed && h_s1[XLEN-1];
        mag_a = a_neg ? -h_s0 : h_s0;
        mag_b = b_neg ? -h_s1 : h_s1;
    end

    // One engine step: shift-add for multiply, restoring subtract for divide
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, e_b} : {(XLEN+1){1'b0}});
        div_trial = {acc_hi, acc_lo[XLEN-1]} - {1'b0, e_b};
        prod_neg  = -{acc_hi, acc_lo};
        fix_hi    = acc_hi;
        fix_lo    = acc_lo;
        if (!e_div) begin
            if (e_neg_res) begin
                fix_hi = prod_neg[2*XLEN-1:XLEN];
                fix_lo = prod_neg[XLEN-1:0];
            end
        end else if (e_div0) begin
            fix_hi = e_a;
            fix_lo = '1;
        end else begin
            fix_lo = e_neg_res ? -acc_lo : acc_lo;
            fix_hi = e_neg_rem ? -acc_hi : acc_hi;
        end
    end

    // Engine next-state: flush aborts from any state
    always_comb begin
        state_nxt = state;
        busy      = (state != E_IDLE);
        if (flush)
            state_nxt = E_IDLE;
        else begin
            case (state)
                E_IDLE:  if (start) state_nxt = E_RUN;
                E_RUN:   if (count == LAST) state_nxt = E_FIX;
                E_FIX:   state_nxt = E_IDLE;
                default: state_nxt = E_IDLE;
            endcase
        end
    end

    // Holding register, engine datapath and HI/LO
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= E_IDLE;
            held      <= 1'b0;
            h_op      <= '0;
            h_s0      <= '0;
            h_s1      <= '0;
            h_dst_vld <= 1'b0;
            h_dst_reg <= '0;
            count     <= '0;
            e_div     <= 1'b0;
            e_div0    <= 1'b0;
            e_neg_res <= 1'b0;
            e_neg_rem <= 1'b0;
            e_a       <= '0;
            e_b       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            state <= state_nxt;

            if (flush)
                held <= 1'b0;
            else if (accept) begin
                held      <= 1'b1;
                h_op      <= in_op;
                h_s0      <= in_s0;
                h_s1      <= in_s1;
                h_dst_vld <= in_dst_vld;
                h_dst_reg <= in_dst_reg;
            end else if (held && (fire || bubble))
                held <= 1'b0;

            if (start) begin
                count     <= '0;
                e_div     <= (h_op == OP_DIV) || (h_op == OP_DIVU);
                e_div0    <= (h_s1 == '0);
                e_neg_res <= a_neg ^ b_neg;
                e_neg_rem <= a_neg;
                e_a       <= h_s0;
                acc_hi    <= '0;
                if ((h_op == OP_DIV) || (h_op == OP_DIVU)) begin
                    e_b    <= mag_b;
                    acc_lo <= mag_a;
                end else begin
                    e_b    <= mag_a;
                    acc_lo <= mag_b;
                end
            end else if ((state == E_RUN) && !flush) begin
                count <= count + 1'b1;
                if (!e_div) begin
                    acc_hi <= mul_sum[XLEN:1];
                    acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                end else if (!div_trial[XLEN]) begin
                    acc_hi <= div_trial[XLEN-1:0];
                    acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
                end else begin
                    acc_hi <= {acc_hi[XLEN-2:0], acc_lo[XLEN-1]};
                    acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
                end
            end

            if (fire && !flush && (h_op == OP_MTHI))
                hi <= h_s0;
            if (fire && !flush && (h_op == OP_MTLO))
                lo <= h_s0;
            if ((state == E_FIX) && !flush) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end
        end
    end

endmodule
